// File: rtl/pc060ha_mailbox_ctrl_if.sv
// Master/slave strobe and data bundle for the PC060HA mailbox controller.
// Strobes are single-cycle and already synchronous to the controller clock.
interface pc060ha_mailbox_ctrl_if #(parameter int DW = 4);
  logic          m_sel;
  logic          m_wr;
  logic          m_rd;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;
  logic          s_sel;
  logic          s_wr;
  logic          s_rd;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;
  logic          s_nmi;
  logic          sub_reset;

  modport master (
    output m_sel, m_wr, m_rd, m_din, s_sel, s_wr, s_rd, s_din,
    input  m_dout, s_dout, s_nmi, sub_reset
  );

  modport slave (
    input  m_sel, m_wr, m_rd, m_din, s_sel, s_wr, s_rd, s_din,
    output m_dout, s_dout, s_nmi, sub_reset
  );
endinterface

// File: rtl/pc060ha_mailbox_ctrl.sv
// Dual-sided 4-slot mailbox with auto-incrementing index registers, full flags, slave NMI and sub-CPU reset.
// Writes land at the strobe edge; read data is registered one cycle after RD; no backpressure (strobes always accepted).
module pc060ha_mailbox_ctrl #(
  parameter int DW       = 4,
  parameter int NMI_SLOT = 3
) (
  input logic                      CLK,
  input logic                      RESET,
  pc060ha_mailbox_ctrl_if.slave    bus
);

  logic [DW-1:0] ms_box [4];
  logic [DW-1:0] sm_box [4];
  logic [3:0]    ms_full, sm_full;
  logic [2:0]    m_idx, s_idx, m_idx_nxt, s_idx_nxt;
  logic [DW-1:0] m_dout, s_dout, m_rdata, s_rdata;
  logic          nmi_en, s_nmi, sub_reset;

  // Write wins over read on a side; the slave side is frozen while held in reset.
  logic m_wr, m_rd, s_wr, s_rd;
  assign m_wr = bus.m_wr;
  assign m_rd = bus.m_rd & ~bus.m_wr;
  assign s_wr = bus.s_wr & ~sub_reset;
  assign s_rd = bus.s_rd & ~bus.s_wr & ~sub_reset;

  logic       m_slot, s_slot;
  logic [1:0] m_k, s_k;
  assign m_slot = bus.m_sel & ~m_idx[2];
  assign s_slot = bus.s_sel & ~s_idx[2];
  assign m_k    = m_idx[1:0];
  assign s_k    = s_idx[1:0];

  logic m_box_wr, m_box_rd, s_box_wr, s_box_rd;
  assign m_box_wr = m_wr & m_slot;
  assign m_box_rd = m_rd & m_slot;
  assign s_box_wr = s_wr & s_slot;
  assign s_box_rd = s_rd & s_slot;

  logic m_ctl_wr, s_ctl_wr;
  assign m_ctl_wr = m_wr & bus.m_sel & (m_idx == 3'd6);
  assign s_ctl_wr = s_wr & bus.s_sel & (s_idx == 3'd6);

  logic [3:0] ms_set, ms_clr, sm_set, sm_clr;
  assign ms_set = m_box_wr ? (4'b0001 << m_k) : 4'b0000;
  assign sm_set = s_box_wr ? (4'b0001 << s_k) : 4'b0000;
  assign ms_clr = s_box_rd ? (4'b0001 << s_k) : 4'b0000;
  assign sm_clr = m_box_rd ? (4'b0001 << m_k) : 4'b0000;

  logic nmi_set, nmi_clr;
  assign nmi_set = m_box_wr & (m_k == 2'(NMI_SLOT)) & nmi_en;
  assign nmi_clr = (s_box_rd & (s_k == 2'(NMI_SLOT))) | (s_ctl_wr & ~bus.s_din[0]);

  always_comb begin
    m_rdata = '0;
    if (!bus.m_sel) m_rdata = DW'(m_idx);
    else begin
      case (m_idx)
        3'd0, 3'd1, 3'd2, 3'd3: m_rdata = sm_box[m_k];
        3'd4:                   m_rdata = DW'(sm_full);
        3'd5:                   m_rdata = DW'(ms_full);
        3'd6:                   m_rdata = DW'(sub_reset);
        default:                m_rdata = '0;
      endcase
    end
  end

  always_comb begin
    s_rdata = '0;
    if (!bus.s_sel) s_rdata = DW'(s_idx);
    else begin
      case (s_idx)
        3'd0, 3'd1, 3'd2, 3'd3: s_rdata = ms_box[s_k];
        3'd4:                   s_rdata = DW'(ms_full);
        3'd5:                   s_rdata = DW'(sm_full);
        3'd6:                   s_rdata = DW'(nmi_en);
        default:                s_rdata = '0;
      endcase
    end
  end

  // Slot accesses step through 0..3 and wrap; control/status indices stay put.
  always_comb begin
    m_idx_nxt = m_idx;
    if (m_wr && !bus.m_sel)          m_idx_nxt = bus.m_din[2:0];
    else if ((m_wr || m_rd) && m_slot) m_idx_nxt = {1'b0, m_k + 2'd1};
    s_idx_nxt = s_idx;
    if (s_wr && !bus.s_sel)          s_idx_nxt = bus.s_din[2:0];
    else if ((s_wr || s_rd) && s_slot) s_idx_nxt = {1'b0, s_k + 2'd1};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        ms_box[i] <= '0;
        sm_box[i] <= '0;
      end
      ms_full   <= '0;
      sm_full   <= '0;
      m_idx     <= '0;
      s_idx     <= '0;
      m_dout    <= '0;
      s_dout    <= '0;
      nmi_en    <= 1'b0;
      s_nmi     <= 1'b0;
      sub_reset <= 1'b1;
    end else begin
      m_idx   <= m_idx_nxt;
      s_idx   <= s_idx_nxt;
      if (m_box_wr) ms_box[m_k] <= bus.m_din;
      if (s_box_wr) sm_box[s_k] <= bus.s_din;
      ms_full <= (ms_full & ~ms_clr) | ms_set;
      sm_full <= (sm_full & ~sm_clr) | sm_set;
      if (m_rd) m_dout <= m_rdata;
      if (s_rd) s_dout <= s_rdata;
      if (m_ctl_wr) sub_reset <= bus.m_din[0];
      if (s_ctl_wr) nmi_en    <= bus.s_din[0];
      if (nmi_set)      s_nmi <= 1'b1;
      else if (nmi_clr) s_nmi <= 1'b0;
    end
  end

  assign bus.m_dout    = m_dout;
  assign bus.s_dout    = s_dout;
  assign bus.s_nmi     = s_nmi;
  assign bus.sub_reset = sub_reset;

endmodule
